// File: rtl/tlb_pkg.sv
// Shared constants and the TLB entry record for tlb_cache and tlb_set.
// Tag and PPN fields are full address width so one struct serves every NUM_SETS/PAGE_BITS.
package tlb_pkg;
   localparam int unsigned VA_W     = 64;
   localparam int unsigned PCID_W   = 12;
   localparam int unsigned NUM_WAYS = 8;
   localparam int unsigned WAY_W    = $clog2(NUM_WAYS);

   typedef struct packed {
      logic              valid;
      logic [VA_W-1:0]   tag;
      logic [PCID_W-1:0] pcid;
      logic [VA_W-1:0]   ppn;
   } tlb_entry_t;
endpackage

// File: rtl/tlb_set.sv
// One TLB set: 8 entries, round-robin pointer, parallel compare and miss fill.
// TLB_PCID_EN: when defined, the context ID is stored and takes part in the match.
module tlb_set
   import tlb_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic [VA_W-1:0]     tag_i,
   input  logic [PCID_W-1:0]   pcid_i,
   input  logic [VA_W-1:0]     ppn_i,
   output logic [NUM_WAYS-1:0] hit_o,
   output logic [VA_W-1:0]     ppn_o
);
   tlb_entry_t       entry_q [NUM_WAYS];
   tlb_entry_t       entry_d [NUM_WAYS];
   logic [WAY_W-1:0] rr_q, rr_d;
   logic [WAY_W-1:0] victim;
   logic             free_found;

`ifndef TLB_PCID_EN
   logic unused_pcid;
   assign unused_pcid = ^pcid_i;
`endif

   always_comb begin
      hit_o = '0;
      ppn_o = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
`ifdef TLB_PCID_EN
         hit_o[w] = entry_q[w].valid && (entry_q[w].tag == tag_i) && (entry_q[w].pcid == pcid_i);
`else
         hit_o[w] = entry_q[w].valid && (entry_q[w].tag == tag_i);
`endif
         if (hit_o[w]) ppn_o = ppn_o | entry_q[w].ppn;
      end
   end

   // Lowest invalid way wins; the pointer is only consulted when the set is full.
   always_comb begin
      free_found = 1'b0;
      victim     = rr_q;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         if (!entry_q[w].valid && !free_found) begin
            free_found = 1'b1;
            victim     = WAY_W'(w);
         end
      end
   end

   always_comb begin
      entry_d = entry_q;
      rr_d    = rr_q;
      if (en_i && (hit_o == '0)) begin
         entry_d[victim].valid = 1'b1;
         entry_d[victim].tag   = tag_i;
`ifdef TLB_PCID_EN
         entry_d[victim].pcid  = pcid_i;
`else
         entry_d[victim].pcid  = '0;
`endif
         entry_d[victim].ppn   = ppn_i;
         if (!free_found) rr_d = rr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned w = 0; w < NUM_WAYS; w++) entry_q[w].valid <= 1'b0;
         rr_q <= '0;
      end else begin
         entry_q <= entry_d;
         rr_q    <= rr_d;
      end
   end
endmodule

// File: rtl/tlb_cache.sv
// Set-associative TLB: one lookup per clock, registered translation and one-hot way hit.
// TLB_PCID_EN selects context-tagged matching (see tlb_set).
module tlb_cache
   import tlb_pkg::*;
#(
   parameter int unsigned NUM_SETS  = 4,
   parameter int unsigned PAGE_BITS = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [VA_W-1:0]     va,
   input  logic [VA_W-1:0]     pa,
   input  logic [PCID_W-1:0]   pcid,
   output logic [VA_W-1:0]     o_addr,
   output logic [NUM_WAYS-1:0] hit
);
   localparam int unsigned     SET_W    = $clog2(NUM_SETS);
   localparam logic [VA_W-1:0] OFF_MASK = (VA_W'(1) << PAGE_BITS) - VA_W'(1);

   logic [SET_W-1:0]    set_idx;
   logic [VA_W-1:0]     tag, ppn_in;
   logic [NUM_WAYS-1:0] set_hit [NUM_SETS];
   logic [VA_W-1:0]     set_ppn [NUM_SETS];
   logic [NUM_WAYS-1:0] hit_d, hit_q;
   logic [VA_W-1:0]     addr_d, addr_q;

   assign set_idx = va[PAGE_BITS +: SET_W];
   assign tag     = va >> (PAGE_BITS + SET_W);
   assign ppn_in  = pa >> PAGE_BITS;

   for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
      tlb_set u_set (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (set_idx == SET_W'(s)),
         .tag_i  (tag),
         .pcid_i (pcid),
         .ppn_i  (ppn_in),
         .hit_o  (set_hit[s]),
         .ppn_o  (set_ppn[s])
      );
   end

   always_comb begin
      hit_d  = set_hit[set_idx];
      addr_d = '0;
      if (|hit_d) addr_d = (set_ppn[set_idx] << PAGE_BITS) | (va & OFF_MASK);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_q  <= '0;
         addr_q <= '0;
      end else begin
         hit_q  <= hit_d;
         addr_q <= addr_d;
      end
   end

   assign hit    = hit_q;
   assign o_addr = addr_q;
endmodule

// File: tb/tb_tlb_cache.sv
// Directed self-checking bench for tlb_cache (defaults: 4 sets, 4 KiB pages).
// Follows TLB_PCID_EN for the context-isolation vectors.
module tb_tlb_cache;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] va, pa, o_addr;
   logic [11:0] pcid;
   logic [7:0]  hit;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        rst_n;
      logic [63:0] va;
      logic [63:0] pa;
      logic [11:0] pcid;
      logic [7:0]  exp_hit;
      logic [63:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   tlb_cache #(.NUM_SETS(4), .PAGE_BITS(12)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .va     (va),
      .pa     (pa),
      .pcid   (pcid),
      .o_addr (o_addr),
      .hit    (hit)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] exp_hit, input logic [63:0] exp_addr);
      checks++;
      if (hit !== exp_hit || o_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s: hit=%h addr=%h, expected hit=%h addr=%h", name, hit, o_addr, exp_hit, exp_addr);
      end
   endtask

   task automatic step(input logic r, input logic [63:0] v, input logic [63:0] p, input logic [11:0] c);
      @(negedge clk);
      rst_n = r;
      va    = v;
      pa    = p;
      pcid  = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      va    = '0;
      pa    = '0;
      pcid  = '0;

      vecs.push_back('{"reset0", 1'b0, 64'h0123_4567_89AB_CDEF, 64'h5000, 12'h0, 8'h00, 64'h0});
      vecs.push_back('{"reset1", 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, 64'h6000, 12'h3, 8'h00, 64'h0});
      vecs.push_back('{"fill_miss", 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 64'h1234_5000, 12'h0, 8'h00, 64'h0});
      vecs.push_back('{"fill_hit", 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 64'h1234_5000, 12'h0, 8'h01, 64'h1234_5FF1});
      vecs.push_back('{"new_offset", 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hDEAD_0000, 12'h0, 8'h01, 64'h1234_5FF2});
      vecs.push_back('{"no_refill", 1'b1, 64'hFFFF_FFFF_FFFF_F000, 64'h0, 12'h0, 8'h01, 64'h1234_5000});
      vecs.push_back('{"other_set_miss", 1'b1, 64'hFFFF_FFFF_FFFF_EFF1, 64'h7000, 12'h0, 8'h00, 64'h0});
      vecs.push_back('{"other_set_hit", 1'b1, 64'hFFFF_FFFF_FFFF_EFF1, 64'h0, 12'h0, 8'h01, 64'h7FF1});
`ifdef TLB_PCID_EN
      vecs.push_back('{"pcid1_miss", 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hABC000, 12'h1, 8'h00, 64'h0});
      vecs.push_back('{"pcid1_hit", 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hABC000, 12'h1, 8'h02, 64'hABCFF2});
      vecs.push_back('{"pcid0_still", 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'h0, 12'h0, 8'h01, 64'h1234_5FF2});
      vecs.push_back('{"pcid1_again", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 12'h1, 8'h02, 64'hABCFFF});
`else
      vecs.push_back('{"pcid_ignored1", 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hABC000, 12'h1, 8'h01, 64'h1234_5FF2});
      vecs.push_back('{"pcid_ignored2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF3, 64'hABC000, 12'h7FF, 8'h01, 64'h1234_5FF3});
`endif

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].va, vecs[i].pa, vecs[i].pcid);
         check(vecs[i].name, vecs[i].exp_hit, vecs[i].exp_addr);
      end

      // Set 0: k<<14 has set index 0 and tag k; fills take ways 0..7 in order.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 64'(k) << 14, 64'(k + 1) << 12, 12'h0);
         check($sformatf("repl_miss%0d", k), 8'h00, 64'h0);
         step(1'b1, 64'(k) << 14, 64'h0, 12'h0);
         check($sformatf("repl_hit%0d", k), 8'h01 << k, (64'(k + 1) << 12));
      end

      step(1'b1, 64'h8 << 14, 64'h99000, 12'h0);
      check("evict_miss", 8'h00, 64'h0);
      step(1'b1, 64'h8 << 14, 64'h0, 12'h0);
      check("evict_way0", 8'h01, 64'h99000);
      step(1'b1, 64'h0, 64'h55000, 12'h0);
      check("va0_evicted", 8'h00, 64'h0);
      step(1'b1, 64'h0, 64'h0, 12'h0);
      check("va0_in_way1", 8'h02, 64'h55000);
      step(1'b1, 64'h2 << 14, 64'h0, 12'h0);
      check("way2_intact", 8'h04, 64'h3000);

      // One-cycle reset pulse wipes the table.
      step(1'b0, 64'h8 << 14, 64'h0, 12'h0);
      check("midreset", 8'h00, 64'h0);
      step(1'b1, 64'h8 << 14, 64'h77000, 12'h0);
      check("post_reset_miss", 8'h00, 64'h0);
      step(1'b1, 64'h8 << 14, 64'h0, 12'h0);
      check("post_reset_refill", 8'h01, 64'h77000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
